// File: rtl/alu_seq_if.sv
// Request/result bus of the sequential ALU: operand/mode request handshake in, result
// plus flags handshake out. The master side drives requests and consumes results.
interface alu_seq_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MODE_WIDTH = 6
);
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_A;
    logic [DATA_WIDTH-1:0] i_B;
    logic [MODE_WIDTH-1:0] i_mode;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_result;
    logic [DATA_WIDTH-1:0] o_result_hi;
    logic                  o_zero;
    logic                  o_neg;
    logic                  o_carry;
    logic                  o_overflow;
    logic                  o_err;

    modport master (
        output i_valid, i_A, i_B, i_mode, i_ready,
        input  o_ready, o_valid, o_result, o_result_hi, o_zero, o_neg, o_carry, o_overflow,
               o_err
    );

    modport slave (
        input  i_valid, i_A, i_B, i_mode, i_ready,
        output o_ready, o_valid, o_result, o_result_hi, o_zero, o_neg, o_carry, o_overflow,
               o_err
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops registered at the accept edge, signed MULT done as an
// iterative shift-add on operand magnitudes with a final sign correction. One op in flight.
module alu_seq #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MODE_WIDTH = 6
) (
    input logic     i_clk,
    input logic     i_reset,
    alu_seq_if.slave bus
);
    localparam int unsigned W    = DATA_WIDTH;
    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

    // Codes compare zero-extended to the mode width.
    localparam logic [MODE_WIDTH-1:0] ModeAdd  = MODE_WIDTH'(6'b100000);
    localparam logic [MODE_WIDTH-1:0] ModeSub  = MODE_WIDTH'(6'b100010);
    localparam logic [MODE_WIDTH-1:0] ModeAnd  = MODE_WIDTH'(6'b100100);
    localparam logic [MODE_WIDTH-1:0] ModeOr   = MODE_WIDTH'(6'b100101);
    localparam logic [MODE_WIDTH-1:0] ModeXor  = MODE_WIDTH'(6'b100110);
    localparam logic [MODE_WIDTH-1:0] ModeNor  = MODE_WIDTH'(6'b100111);
    localparam logic [MODE_WIDTH-1:0] ModeSra  = MODE_WIDTH'(6'b000011);
    localparam logic [MODE_WIDTH-1:0] ModeSrl  = MODE_WIDTH'(6'b000010);
    localparam logic [MODE_WIDTH-1:0] ModeSll  = MODE_WIDTH'(6'b000000);
    localparam logic [MODE_WIDTH-1:0] ModeMult = MODE_WIDTH'(6'b011000);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]      a_mag_q, a_mag_d;
    logic              sign_q, sign_d;
    logic [2*W-1:0]    prod_q, prod_d;
    logic [W-1:0]      result_q, result_d;
    logic [W-1:0]      result_hi_q, result_hi_d;
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;
    logic              carry_q, carry_d;
    logic              overflow_q, overflow_d;
    logic              err_q, err_d;

    logic [W:0]        sum_ext, diff_ext;
    logic [W-1:0]      alu_res;
    logic              alu_carry, alu_ovf, alu_err, alu_is_mul;
    logic [W-1:0]      a_mag_in, b_mag_in;
    logic [W:0]        mul_add;
    logic [2*W-1:0]    mul_step, mul_final;

    // Single-cycle result from the live request inputs (used only at the accept edge).
    always_comb begin
        alu_res    = '0;
        alu_carry  = 1'b0;
        alu_ovf    = 1'b0;
        alu_err    = 1'b0;
        alu_is_mul = 1'b0;
        sum_ext    = {1'b0, bus.i_A} + {1'b0, bus.i_B};
        diff_ext   = {1'b0, bus.i_A} - {1'b0, bus.i_B};
        case (bus.i_mode)
            ModeAdd: begin
                alu_res   = sum_ext[W-1:0];
                alu_carry = sum_ext[W];
                alu_ovf   = (bus.i_A[W-1] == bus.i_B[W-1]) && (sum_ext[W-1] != bus.i_A[W-1]);
            end
            ModeSub: begin
                alu_res   = diff_ext[W-1:0];
                alu_carry = diff_ext[W];  // borrow: A < B unsigned
                alu_ovf   = (bus.i_A[W-1] != bus.i_B[W-1]) && (diff_ext[W-1] != bus.i_A[W-1]);
            end
            ModeAnd:  alu_res = bus.i_A & bus.i_B;
            ModeOr:   alu_res = bus.i_A | bus.i_B;
            ModeXor:  alu_res = bus.i_A ^ bus.i_B;
            ModeNor:  alu_res = ~(bus.i_A | bus.i_B);
            // Shift amounts >= W already yield 0 / sign fill under the language's semantics.
            ModeSra:  alu_res = $signed(bus.i_A) >>> bus.i_B;
            ModeSrl:  alu_res = bus.i_A >> bus.i_B;
            ModeSll:  alu_res = bus.i_A << bus.i_B;
            ModeMult: alu_is_mul = 1'b1;
            default:  alu_err = 1'b1;
        endcase
    end

    // Multiply datapath: operand magnitudes at accept, one shift-add step per MUL cycle.
    always_comb begin
        a_mag_in  = bus.i_A[W-1] ? -bus.i_A : bus.i_A;
        b_mag_in  = bus.i_B[W-1] ? -bus.i_B : bus.i_B;
        mul_add   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);
        mul_step  = {mul_add, prod_q[W-1:1]};
        mul_final = sign_q ? -mul_step : mul_step;
    end

    // Next-state: FSM transitions and register updates on accept / completion.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_mag_d     = a_mag_q;
        sign_d      = sign_q;
        prod_d      = prod_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        err_d       = err_q;
        case (state_q)
            StIdle: begin
                if (bus.i_valid) begin
                    if (alu_is_mul) begin
                        state_d = StMul;
                        cnt_d   = CntW'(W);
                        a_mag_d = a_mag_in;
                        sign_d  = bus.i_A[W-1] ^ bus.i_B[W-1];
                        prod_d  = {{W{1'b0}}, b_mag_in};
                    end else begin
                        state_d     = StDone;
                        result_d    = alu_res;
                        result_hi_d = '0;
                        zero_d      = !alu_err && (alu_res == '0);
                        neg_d       = alu_res[W-1];
                        carry_d     = alu_carry;
                        overflow_d  = alu_ovf;
                        err_d       = alu_err;
                    end
                end
            end
            StMul: begin
                prod_d = mul_step;
                cnt_d  = cnt_q - CntW'(1);
                // Last iteration: register the sign-corrected product directly.
                if (cnt_q == CntW'(1)) begin
                    state_d     = StDone;
                    result_d    = mul_final[W-1:0];
                    result_hi_d = mul_final[2*W-1:W];
                    zero_d      = (mul_final[W-1:0] == '0);
                    neg_d       = mul_final[W-1];
                    carry_d     = 1'b0;
                    overflow_d  = mul_final[2*W-1:W] != {W{mul_final[W-1]}};
                    err_d       = 1'b0;
                end
            end
            StDone: begin
                if (bus.i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, cleared by asynchronous reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_mag_q     <= '0;
            sign_q      <= 1'b0;
            prod_q      <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_mag_q     <= a_mag_d;
            sign_q      <= sign_d;
            prod_q      <= prod_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            err_q       <= err_d;
        end
    end

    assign bus.o_ready     = (state_q == StIdle);
    assign bus.o_valid     = (state_q == StDone);
    assign bus.o_result    = result_q;
    assign bus.o_result_hi = result_hi_q;
    assign bus.o_zero      = zero_q;
    assign bus.o_neg       = neg_q;
    assign bus.o_carry     = carry_q;
    assign bus.o_overflow  = overflow_q;
    assign bus.o_err       = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (8-bit): directed vector table, randomized ops against an arithmetic
// reference model, backpressure and mid-MULT reset sequences.
module tb_alu_seq;
    typedef struct packed {
        logic [7:0] res;
        logic [7:0] hi;
        logic       zero;
        logic       neg;
        logic       carry;
        logic       ovf;
        logic       err;
        int         lat;
    } out_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] mode;
        out_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    alu_seq_if #(.DATA_WIDTH(8), .MODE_WIDTH(6)) bus ();

    alu_seq #(.DATA_WIDTH(8), .MODE_WIDTH(6)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the signed/unsigned operand values.
    function automatic out_t model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] m);
        out_t o;
        int sa, sb, ua, ub, r, sh;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        sh = (ub > 8) ? 8 : ub;
        o = '0;
        o.lat = 1;
        r = 0;
        case (m)
            6'b100000: begin
                r = ua + ub;
                o.carry = (r > 255);
                o.ovf = (sa + sb > 127) || (sa + sb < -128);
            end
            6'b100010: begin
                r = ua - ub;
                o.carry = (ua < ub);
                o.ovf = (sa - sb > 127) || (sa - sb < -128);
            end
            6'b100100: r = ua & ub;
            6'b100101: r = ua | ub;
            6'b100110: r = ua ^ ub;
            6'b100111: r = ~(ua | ub);
            6'b000011: r = sa >>> sh;
            6'b000010: r = ua >> sh;
            6'b000000: r = ua << sh;
            6'b011000: begin
                r = sa * sb;
                o.hi = r[15:8];
                o.ovf = (r > 127) || (r < -128);
                o.lat = 9;
            end
            default: o.err = 1'b1;
        endcase
        o.res = r[7:0];
        if (!o.err) begin
            o.zero = (o.res == 8'h00);
            o.neg = o.res[7];
        end
        return o;
    endfunction

    function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [5:0] m,
                                input logic [7:0] res, input logic [7:0] hi, input logic z,
                                input logic n, input logic c, input logic v, input logic e,
                                input int lat);
        vec_t t;
        t.a = a; t.b = b; t.mode = m;
        t.exp.res = res; t.exp.hi = hi; t.exp.zero = z; t.exp.neg = n;
        t.exp.carry = c; t.exp.ovf = v; t.exp.err = e; t.exp.lat = lat;
        return t;
    endfunction

    task automatic chk_out(input string tag, input out_t got, input out_t exp);
        chk({tag, ".res"}, int'(got.res), int'(exp.res));
        chk({tag, ".hi"}, int'(got.hi), int'(exp.hi));
        chk({tag, ".zero"}, int'(got.zero), int'(exp.zero));
        chk({tag, ".neg"}, int'(got.neg), int'(exp.neg));
        chk({tag, ".carry"}, int'(got.carry), int'(exp.carry));
        chk({tag, ".ovf"}, int'(got.ovf), int'(exp.ovf));
        chk({tag, ".err"}, int'(got.err), int'(exp.err));
        chk({tag, ".lat"}, got.lat, exp.lat);
    endtask

    // Issue one op, count edges to o_valid, capture outputs, then retire it.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [5:0] m,
                          output out_t got);
        int waitc = 0;
        got = '0;
        while (!bus.o_ready && waitc < 20) begin
            @(posedge clk); #1; waitc++;
        end
        if (!bus.o_ready) begin
            compared++; mismatched++;
            $display("FAIL ready_timeout: got o_ready=0 expected 1");
        end
        bus.i_A = a; bus.i_B = b; bus.i_mode = m; bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.i_A = 8'($urandom); bus.i_B = 8'($urandom); bus.i_mode = 6'($urandom);
        got.lat = 1;
        while (!bus.o_valid && got.lat < 30) begin
            @(posedge clk); #1; got.lat++;
        end
        if (!bus.o_valid) begin
            compared++; mismatched++;
            $display("FAIL valid_timeout: got o_valid=0 expected 1");
        end
        got.res = bus.o_result; got.hi = bus.o_result_hi; got.zero = bus.o_zero;
        got.neg = bus.o_neg; got.carry = bus.o_carry; got.ovf = bus.o_overflow;
        got.err = bus.o_err;
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
    endtask

    // o_ready and o_valid must never be high together.
    always @(negedge clk) begin
        compared++;
        if (bus.o_ready && bus.o_valid) begin
            mismatched++;
            $display("FAIL ready_valid_excl: got both 1 expected not both");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[15];
        out_t       got, exp;
        logic [5:0] codes[10];
        logic [5:0] m;
        logic [7:0] a, b;

        bus.i_valid = 1'b0; bus.i_ready = 1'b0;
        bus.i_A = '0; bus.i_B = '0; bus.i_mode = '0;

        //            a      b      mode       res    hi     z  n  c  v  e  lat
        vecs[0]  = mk(8'h7F, 8'h01, 6'b100000, 8'h80, 8'h00, 0, 1, 0, 1, 0, 1);
        vecs[1]  = mk(8'h00, 8'h01, 6'b100010, 8'hFF, 8'h00, 0, 1, 1, 0, 0, 1);
        vecs[2]  = mk(8'h80, 8'h01, 6'b100010, 8'h7F, 8'h00, 0, 0, 0, 1, 0, 1);
        vecs[3]  = mk(8'hFD, 8'h05, 6'b011000, 8'hF1, 8'hFF, 0, 1, 0, 0, 0, 9);
        vecs[4]  = mk(8'h10, 8'h10, 6'b011000, 8'h00, 8'h01, 1, 0, 0, 1, 0, 9);
        vecs[5]  = mk(8'h80, 8'h80, 6'b011000, 8'h00, 8'h40, 1, 0, 0, 1, 0, 9);
        vecs[6]  = mk(8'h80, 8'h09, 6'b000011, 8'hFF, 8'h00, 0, 1, 0, 0, 0, 1);
        vecs[7]  = mk(8'h80, 8'h03, 6'b000010, 8'h10, 8'h00, 0, 0, 0, 0, 0, 1);
        vecs[8]  = mk(8'h01, 8'h07, 6'b000000, 8'h80, 8'h00, 0, 1, 0, 0, 0, 1);
        vecs[9]  = mk(8'h01, 8'h08, 6'b000000, 8'h00, 8'h00, 1, 0, 0, 0, 0, 1);
        vecs[10] = mk(8'h55, 8'h22, 6'b111111, 8'h00, 8'h00, 0, 0, 0, 0, 1, 1);
        vecs[11] = mk(8'hFF, 8'h01, 6'b100000, 8'h00, 8'h00, 1, 0, 1, 0, 0, 1);
        vecs[12] = mk(8'h00, 8'h00, 6'b100111, 8'hFF, 8'h00, 0, 1, 0, 0, 0, 1);
        vecs[13] = mk(8'h0C, 8'h30, 6'b100101, 8'h3C, 8'h00, 0, 0, 0, 0, 0, 1);
        vecs[14] = mk(8'hA5, 8'h5A, 6'b100110, 8'hFF, 8'h00, 0, 1, 0, 0, 0, 1);

        codes = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                  6'b100111, 6'b000011, 6'b000010, 6'b000000, 6'b011000};

        // Reset state while reset is held.
        #3;
        chk("rst.ready", int'(bus.o_ready), 1);
        chk("rst.valid", int'(bus.o_valid), 0);
        chk("rst.result", int'(bus.o_result), 0);
        chk("rst.err", int'(bus.o_err), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].mode, got);
            chk_out($sformatf("vec%0d", i), got, vecs[i].exp);
        end

        for (int i = 0; i < 60; i++) begin
            int k;
            k = $urandom_range(0, 11);
            m = (k >= 10) ? 6'($urandom_range(0, 63)) : codes[k];
            a = 8'($urandom);
            b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 12)) : 8'($urandom);
            exp = model(a, b, m);
            run_op(a, b, m, got);
            chk_out($sformatf("rnd%0d_m%0b_a%0h_b%0h", i, m, a, b), got, exp);
        end

        // Backpressure: AND held in DONE for 5 cycles, stray request ignored.
        bus.i_A = 8'hF0; bus.i_B = 8'h3C; bus.i_mode = 6'b100100; bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        chk("bp.valid_lat1", int'(bus.o_valid), 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp.result", int'(bus.o_result), 8'h30);
            chk("bp.ready", int'(bus.o_ready), 0);
            chk("bp.valid", int'(bus.o_valid), 1);
            chk("bp.zero", int'(bus.o_zero), 0);
            chk("bp.neg", int'(bus.o_neg), 0);
            if (i == 1) begin
                bus.i_A = 8'h01; bus.i_B = 8'h01; bus.i_mode = 6'b100000; bus.i_valid = 1'b1;
            end
            if (i == 2) bus.i_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        chk("bp.valid_drop", int'(bus.o_valid), 0);
        chk("bp.ready_back", int'(bus.o_ready), 1);
        @(posedge clk); #1;
        chk("bp.no_queue", int'(bus.o_valid), 0);
        chk("bp.result_held", int'(bus.o_result), 8'h30);

        // Reset 4 cycles into a MULT; then a fresh ADD must be clean.
        bus.i_A = 8'h7F; bus.i_B = 8'h7F; bus.i_mode = 6'b011000; bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst.ready", int'(bus.o_ready), 1);
        chk("mrst.valid", int'(bus.o_valid), 0);
        chk("mrst.result", int'(bus.o_result), 0);
        chk("mrst.hi", int'(bus.o_result_hi), 0);
        chk("mrst.flags", int'({bus.o_zero, bus.o_neg, bus.o_carry, bus.o_overflow,
                                bus.o_err}), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(8'h02, 8'h03, 6'b100000, got);
        chk_out("post_rst_add", got, mk(8'h02, 8'h03, 6'b100000, 8'h05, 8'h00,
                                        0, 0, 0, 0, 0, 1).exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
